// File: rtl/sprite_palette_bank.sv
// Multi-palette colour lookup for sprites: runtime-writable palette bank, frame-synchronous
// palette selection with optional base/alt flashing, one-cycle registered RGB + transparency flag.

module sprite_palette_bank_pal #(
    parameter int IDX_W = 4,
    parameter int DW    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [IDX_W-1:0]                waddr,
    input  logic [DW-1:0]                   wdata,
    output logic [(2**IDX_W)-1:0][DW-1:0]   ents
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ents <= '0;
        else if (we)
            ents[waddr] <= wdata;
    end
endmodule

module sprite_palette_bank #(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 4,
    parameter int NUM_PAL      = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int TRANSP_IDX   = 0,
    parameter int PAL_W        = (NUM_PAL > 2) ? $clog2(NUM_PAL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PAL_W-1:0]  wr_pal,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic [PAL_W-1:0]  pal_sel,
    input  logic              flash_en,
    input  logic [PAL_W-1:0]  flash_alt,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  index,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              out_valid,
    output logic              transparent,
    output logic [PAL_W-1:0]  active_pal
);
    localparam int NENT   = 2**IDX_W;
    localparam int DW     = 3*CH_W;
    localparam int STAGES = 1;
    localparam int FC_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_MAX = FC_W'(FLASH_FRAMES-1);
    localparam logic [PAL_W:0]   NPAL   = (PAL_W+1)'(NUM_PAL);
    localparam logic [IDX_W-1:0] TIDX   = IDX_W'(TRANSP_IDX);

    typedef enum logic {BASE = 1'b0, ALT = 1'b1} fl_t;

    // ---------------- palette storage ----------------
    logic [NUM_PAL-1:0][NENT-1:0][DW-1:0] ents;
    logic [NUM_PAL-1:0]                   pal_we;

    // Out-of-range wr_pal matches no bank, so such writes fall away naturally.
    genvar g;
    generate
        for (g = 0; g < NUM_PAL; g++) begin : g_pal
            assign pal_we[g] = wr_en && (wr_pal == PAL_W'(g));
            sprite_palette_bank_pal #(
                .IDX_W (IDX_W),
                .DW    (DW)
            ) u_pal (
                .clk   (clk),
                .rst   (rst),
                .we    (pal_we[g]),
                .waddr (wr_idx),
                .wdata (wr_rgb),
                .ents  (ents[g])
            );
        end
    endgenerate

    // ---------------- lookup with write-through ----------------
    logic [NENT-1:0][DW-1:0] cur_pal;
    logic [DW-1:0]           rd_mem;
    logic [DW-1:0]           rd_rgb;
    logic                    fwd;

    assign cur_pal = ents[active_pal];
    assign rd_mem  = cur_pal[index];
    assign fwd     = wr_en && (wr_pal == active_pal) && (wr_idx == index);
    assign rd_rgb  = fwd ? wr_rgb : rd_mem;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;

    assign vld_pipe  = {vld_q, pix_valid};
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[STAGES-1:0];
    end

    // Colour and transparency hold their last value while pix_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else if (pix_valid) begin
            {red, green, blue} <= rd_rgb;
            transparent        <= (index == TIDX);
        end
    end

    // ---------------- flash FSM ----------------
    fl_t              state, state_d;
    logic [FC_W-1:0]  fcnt, fcnt_d;
    logic [PAL_W-1:0] base_pal, base_d, act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BASE;
            fcnt       <= '0;
            base_pal   <= '0;
            active_pal <= '0;
        end else begin
            state      <= state_d;
            fcnt       <= fcnt_d;
            base_pal   <= base_d;
            active_pal <= act_d;
        end
    end

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        if (!flash_en) begin
            state_d = BASE;
            fcnt_d  = '0;
        end else if (frame_start) begin
            if (fcnt == FC_MAX) begin
                fcnt_d  = '0;
                state_d = (state == BASE) ? ALT : BASE;
            end else begin
                fcnt_d = fcnt + 1'b1;
            end
        end
    end

    // Active palette follows the values loaded on the same edge, so base and flash changes land together.
    always_comb begin
        base_d = base_pal;
        act_d  = active_pal;
        if (frame_start) begin
            if ({1'b0, pal_sel} < NPAL)
                base_d = pal_sel;
            act_d = ((state_d == ALT) && ({1'b0, flash_alt} < NPAL)) ? flash_alt : base_d;
        end
    end
endmodule
